// File: rtl/conv_result_collector_if.sv
// -----------------------------------------------------------------------------
// conv_result_collector_if
// Purpose : Bundles the capture-side and stream-side signals of the
//           convolution result collector into one interface.
// Signals :
//   start      master->slave  1-cycle pulse, clear and begin a new frame
//   in_valid   master->slave  result word valid this cycle
//   in_data    master->slave  result word from the MAC unit (N bits)
//   out_ready  master->slave  downstream accepts the current beat
//   out_valid  slave->master  out_data/out_row/out_col/out_last valid
//   out_data   slave->master  buffered result word (N bits)
//   out_row    slave->master  output row index (A bits)
//   out_col    slave->master  output column index (A bits)
//   out_last   slave->master  final beat of the frame
//   busy       slave->master  collector not idle
//   frame_done slave->master  1-cycle pulse after the last beat handshake
//   ovf_err    slave->master  sticky: word arrived outside collection
// -----------------------------------------------------------------------------
interface conv_result_collector_if #(
   parameter int N = 8,
   parameter int A = 4
);
   logic         start;
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         out_ready;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic [A-1:0] out_row;
   logic [A-1:0] out_col;
   logic         out_last;
   logic         busy;
   logic         frame_done;
   logic         ovf_err;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  out_valid, out_data, out_row, out_col, out_last,
             busy, frame_done, ovf_err
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output out_valid, out_data, out_row, out_col, out_last,
             busy, frame_done, ovf_err
   );
endinterface

// File: rtl/conv_result_collector.sv
// -----------------------------------------------------------------------------
// conv_result_collector
// Purpose : Captures one (P-2)x(P-2) frame of MAC results into a local buffer,
//           then streams it out over valid/ready with row/col tags.
// Ports   :
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      conv_result_collector_if.slave (capture + stream handshake)
// Parameters:
//   N     result word width
//   P     input image side; the output frame is (P-2)x(P-2)
//   A     buffer address width, 2**A >= (P-2)*(P-2)
//   RELU  1 = negative results are clamped to zero on capture
// -----------------------------------------------------------------------------
module conv_result_collector #(
   parameter int N    = 8,
   parameter int P    = 5,
   parameter int A    = 4,
   parameter int RELU = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   conv_result_collector_if.slave    bus
);

   localparam int SIDE = P - 2;
   localparam int NOUT = SIDE * SIDE;
   localparam int RW   = A + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   state_t         r_state;
   logic [A-1:0]   r_wptr;
   logic [RW-1:0]  r_rptr;
   logic [A-1:0]   r_rd_row;
   logic [A-1:0]   r_rd_col;
   logic           r_rd_done;
   logic           r_out_valid;
   logic [N-1:0]   r_out_data;
   logic [A-1:0]   r_out_row;
   logic [A-1:0]   r_out_col;
   logic           r_out_last;
   logic           r_frame_done;
   logic           r_ovf_err;

   logic [N-1:0]   r_mem [0:(2**A)-1];

   logic           w_wr_en;
   logic           w_hs;
   logic           w_load;

   // Negative two's-complement words are clamped to zero when RELU is enabled.
   function automatic logic [N-1:0] relu_clamp(input logic [N-1:0] d);
      if ((RELU != 0) && d[N-1]) begin
         return '0;
      end
      return d;
   endfunction

   // start has priority: a word arriving with start is dropped.
   assign w_wr_en = (r_state == S_COLLECT) && bus.in_valid && !bus.start;
   assign w_hs    = r_out_valid && bus.out_ready;
   // The output register doubles as the read register; it is refilled
   // whenever it is empty or its current beat is being accepted, which
   // gives one beat per cycle under continuous out_ready.
   assign w_load  = (r_state == S_DRAIN) && !r_rd_done &&
                    (!r_out_valid || bus.out_ready);

   // ---- capture stage: buffer write (contents need no reset) ----
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wptr] <= relu_clamp(bus.in_data);
      end
   end

   // ---- control / drain stage ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_rd_row     <= '0;
         r_rd_col     <= '0;
         r_rd_done    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_row    <= '0;
         r_out_col    <= '0;
         r_out_last   <= 1'b0;
         r_frame_done <= 1'b0;
         r_ovf_err    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (bus.start) begin
            r_state     <= S_COLLECT;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_ovf_err   <= 1'b0;
         end else begin
            if (bus.in_valid && (r_state != S_COLLECT)) begin
               r_ovf_err <= 1'b1;
            end
            case (r_state)
               S_COLLECT: begin
                  if (bus.in_valid) begin
                     r_wptr <= r_wptr + 1'b1;
                     if (r_wptr == A'(NOUT - 1)) begin
                        r_state   <= S_DRAIN;
                        r_rptr    <= '0;
                        r_rd_row  <= '0;
                        r_rd_col  <= '0;
                        r_rd_done <= 1'b0;
                     end
                  end
               end
               S_DRAIN: begin
                  if (w_hs && r_out_last) begin
                     r_out_valid  <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_state      <= S_IDLE;
                     r_frame_done <= 1'b1;
                  end else if (w_load) begin
                     r_out_data  <= r_mem[r_rptr[A-1:0]];
                     r_out_row   <= r_rd_row;
                     r_out_col   <= r_rd_col;
                     r_out_last  <= (r_rptr == RW'(NOUT - 1));
                     r_out_valid <= 1'b1;
                     r_rptr      <= r_rptr + 1'b1;
                     r_rd_done   <= (r_rptr == RW'(NOUT - 1));
                     if (r_rd_col == A'(SIDE - 1)) begin
                        r_rd_col <= '0;
                        r_rd_row <= r_rd_row + 1'b1;
                     end else begin
                        r_rd_col <= r_rd_col + 1'b1;
                     end
                  end else if (w_hs) begin
                     r_out_valid <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_row    = r_out_row;
   assign bus.out_col    = r_out_col;
   assign bus.out_last   = r_out_last;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.frame_done = r_frame_done;
   assign bus.ovf_err    = r_ovf_err;

endmodule

// File: tb/tb_conv_result_collector.sv
// -----------------------------------------------------------------------------
// tb_conv_result_collector
// Two collectors (RELU off / RELU on) share one stimulus stream; each one's
// outputs are compared against a frame model kept as queues of expected words.
// -----------------------------------------------------------------------------
module tb_conv_result_collector;
   localparam int N    = 8;
   localparam int P    = 5;
   localparam int A    = 4;
   localparam int SIDE = P - 2;
   localparam int NOUT = SIDE * SIDE;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       t_start = 1'b0;
   logic       t_iv    = 1'b0;
   logic       t_rdy   = 1'b0;
   logic [7:0] t_data  = 8'h00;

   conv_result_collector_if #(.N(N), .A(A)) bus0 ();
   conv_result_collector_if #(.N(N), .A(A)) bus1 ();

   assign bus0.start = t_start;  assign bus1.start = t_start;
   assign bus0.in_valid = t_iv;  assign bus1.in_valid = t_iv;
   assign bus0.in_data = t_data; assign bus1.in_data = t_data;
   assign bus0.out_ready = t_rdy; assign bus1.out_ready = t_rdy;

   conv_result_collector #(.N(N), .P(P), .A(A), .RELU(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
   conv_result_collector #(.N(N), .P(P), .A(A), .RELU(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

   logic         o_valid [2];
   logic         o_last  [2];
   logic         o_busy  [2];
   logic         o_fd    [2];
   logic         o_ovf   [2];
   logic [N-1:0] o_data  [2];
   logic [A-1:0] o_row   [2];
   logic [A-1:0] o_col   [2];

   assign o_valid[0] = bus0.out_valid;  assign o_valid[1] = bus1.out_valid;
   assign o_last[0]  = bus0.out_last;   assign o_last[1]  = bus1.out_last;
   assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;
   assign o_fd[0]    = bus0.frame_done; assign o_fd[1]    = bus1.frame_done;
   assign o_ovf[0]   = bus0.ovf_err;    assign o_ovf[1]   = bus1.ovf_err;
   assign o_data[0]  = bus0.out_data;   assign o_data[1]  = bus1.out_data;
   assign o_row[0]   = bus0.out_row;    assign o_row[1]   = bus1.out_row;
   assign o_col[0]   = bus0.out_col;    assign o_col[1]   = bus1.out_col;

   int nvec = 0;
   int nerr = 0;

   // Frame model: expected drained words per instance, and expected ovf flag.
   logic [7:0] expq0[$];
   logic [7:0] expq1[$];
   bit         model_ovf = 1'b0;

   typedef struct {
      bit         start;
      bit         iv;
      logic [7:0] data;
      bit         rdy;
      bit         e_valid;
      logic [7:0] e_data;
      int         e_row;
      int         e_col;
      bit         e_last;
      bit         e_busy;
      bit         e_fd;
   } vec_t;

   vec_t tbl[21];

   task automatic chk(input string nm, input int inst,
                      input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, inst, act, exp);
      end
   endtask

   function automatic logic [7:0] relu_ref(input logic [7:0] d);
      return (d >= 8'h80) ? 8'h00 : d;
   endfunction

   function automatic logic [7:0] exp_word(input int inst, input int k);
      return (inst == 0) ? expq0[k] : expq1[k];
   endfunction

   // Pulse start (optionally with a simultaneous word that must be dropped),
   // then present the given words on consecutive cycles.
   task automatic fill(input logic [7:0] d[$], input bit word_with_start);
      t_start = 1'b1; t_iv = word_with_start; t_data = 8'h55; t_rdy = 1'b0;
      @(negedge clk);
      t_start = 1'b0; t_iv = 1'b0;
      expq0.delete(); expq1.delete(); model_ovf = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("start_ovf_clear", i, 32'(o_ovf[i]), 32'd0);
         chk("start_busy", i, 32'(o_busy[i]), 32'd1);
         chk("start_valid", i, 32'(o_valid[i]), 32'd0);
      end
      foreach (d[k]) begin
         t_iv = 1'b1; t_data = d[k];
         if (expq0.size() < NOUT) begin
            expq0.push_back(d[k]);
            expq1.push_back(relu_ref(d[k]));
         end
         @(negedge clk);
      end
      t_iv = 1'b0;
   endtask

   // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready.
   // stop_at < 0 drains the whole frame; otherwise returns after that many beats.
   task automatic drain(input int stop_at, input int mode, input bit inject);
      int  idx = 0;
      int  cyc = 0;
      int  target;
      bit  rdy;
      target = (stop_at < 0) ? NOUT : stop_at;
      while (idx < target && cyc < 100) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 3) == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         if (inject && cyc == 3) begin
            t_iv = 1'b1; t_data = 8'hAA; model_ovf = 1'b1;
         end else begin
            t_iv = 1'b0;
         end
         t_rdy = rdy;
         for (int i = 0; i < 2; i++) begin
            chk("drain_busy", i, 32'(o_busy[i]), 32'd1);
            chk("drain_fd_early", i, 32'(o_fd[i]), 32'd0);
            if (o_valid[i] && idx < NOUT) begin
               chk("beat_data", i, 32'(o_data[i]), 32'(exp_word(i, idx)));
               chk("beat_row", i, 32'(o_row[i]), 32'(idx / SIDE));
               chk("beat_col", i, 32'(o_col[i]), 32'(idx % SIDE));
               chk("beat_last", i, 32'(o_last[i]), 32'(idx == NOUT - 1));
            end else begin
               chk("idle_last", i, 32'(o_last[i]), 32'd0);
            end
         end
         if (o_valid[0] && rdy) idx++;
         @(negedge clk);
         cyc++;
      end
      t_iv = 1'b0;
      if (idx < target) chk("drain_timeout", 0, 32'(idx), 32'(target));
      if (stop_at < 0) begin
         for (int i = 0; i < 2; i++) begin
            chk("end_fd", i, 32'(o_fd[i]), 32'd1);
            chk("end_valid", i, 32'(o_valid[i]), 32'd0);
            chk("end_busy", i, 32'(o_busy[i]), 32'd0);
            chk("end_last", i, 32'(o_last[i]), 32'd0);
            chk("end_ovf", i, 32'(o_ovf[i]), 32'(model_ovf));
         end
         t_rdy = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk("fd_pulse", i, 32'(o_fd[i]), 32'd0);
            chk("idle_busy", i, 32'(o_busy[i]), 32'd0);
            chk("idle_valid", i, 32'(o_valid[i]), 32'd0);
         end
      end
   endtask

   initial begin
      logic [7:0] q[$];

      // Reset state
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", i, 32'(o_valid[i]), 32'd0);
         chk("rst_busy", i, 32'(o_busy[i]), 32'd0);
         chk("rst_fd", i, 32'(o_fd[i]), 32'd0);
         chk("rst_ovf", i, 32'(o_ovf[i]), 32'd0);
         chk("rst_last", i, 32'(o_last[i]), 32'd0);
         chk("rst_data", i, 32'(o_data[i]), 32'd0);
         chk("rst_row", i, 32'(o_row[i]), 32'd0);
         chk("rst_col", i, 32'(o_col[i]), 32'd0);
      end
      rst_n = 1'b1;

      // Basic frame, cycle-exact: start, 9 captures of 1..9, one latency
      // cycle, 9 back-to-back beats, frame_done pulse.
      for (int k = 0; k < 21; k++) begin
         tbl[k].start   = (k == 0);
         tbl[k].iv      = (k >= 1 && k <= 9);
         tbl[k].data    = (k >= 1 && k <= 9) ? 8'(k) : 8'h00;
         tbl[k].rdy     = 1'b1;
         tbl[k].e_valid = (k >= 10 && k <= 18);
         tbl[k].e_data  = 8'(k - 9);
         tbl[k].e_row   = (k - 10) / SIDE;
         tbl[k].e_col   = (k - 10) % SIDE;
         tbl[k].e_last  = (k == 18);
         tbl[k].e_busy  = (k <= 18);
         tbl[k].e_fd    = (k == 19);
      end
      for (int k = 0; k < 21; k++) begin
         t_start = tbl[k].start; t_iv = tbl[k].iv;
         t_data = tbl[k].data; t_rdy = tbl[k].rdy;
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk("t1_valid", i, 32'(o_valid[i]), 32'(tbl[k].e_valid));
            chk("t1_busy", i, 32'(o_busy[i]), 32'(tbl[k].e_busy));
            chk("t1_fd", i, 32'(o_fd[i]), 32'(tbl[k].e_fd));
            chk("t1_last", i, 32'(o_last[i]), 32'(tbl[k].e_last));
            chk("t1_ovf", i, 32'(o_ovf[i]), 32'd0);
            if (tbl[k].e_valid) begin
               chk("t1_data", i, 32'(o_data[i]), 32'(tbl[k].e_data));
               chk("t1_row", i, 32'(o_row[i]), 32'(tbl[k].e_row));
               chk("t1_col", i, 32'(o_col[i]), 32'(tbl[k].e_col));
            end
         end
      end
      t_start = 1'b0; t_iv = 1'b0; t_rdy = 1'b0;

      // Backpressure with ready pattern 1,0,0
      q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      fill(q, 1'b0);
      drain(-1, 1, 1'b0);

      // Word arriving during drain sets ovf_err; drained data untouched
      fill(q, 1'b0);
      drain(-1, 0, 1'b1);

      // Restart mid-collect, with a word coincident with start (dropped)
      fill('{8'd21, 8'd22, 8'd23, 8'd24}, 1'b0);
      q = {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
      fill(q, 1'b1);
      drain(-1, 0, 1'b0);

      // Negative values clamp only on the RELU instance
      q = {8'hF0, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
      fill(q, 1'b0);
      drain(-1, 0, 1'b0);

      // Async reset after three beats of a drain
      q = {8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39};
      fill(q, 1'b0);
      drain(3, 0, 1'b1);
      for (int i = 0; i < 2; i++) chk("pre_rst_ovf", i, 32'(o_ovf[i]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async_rst_valid", i, 32'(o_valid[i]), 32'd0);
         chk("async_rst_busy", i, 32'(o_busy[i]), 32'd0);
         chk("async_rst_ovf", i, 32'(o_ovf[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q = {8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47, 8'd48, 8'd49};
      fill(q, 1'b0);
      drain(-1, 0, 1'b0);

      // Randomized frames with random backpressure and overflow words
      for (int f = 0; f < 6; f++) begin
         q.delete();
         for (int k = 0; k < NOUT; k++) q.push_back(8'($urandom_range(0, 255)));
         fill(q, 1'($urandom_range(0, 1)));
         drain(-1, 2, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout inst0: got 0x1 expected 0x0");
      $fatal(1, "timeout");
   end
endmodule
